// File: rtl/dac_bank_pkg.sv
// Shared types and helpers for the DAC channel bank: FSM state encoding,
// SPI frame length, saturation limits and offset-binary conversions.
package dac_bank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILTER,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam int          FRAME_BITS = 24;
  localparam logic [17:0] D_MAX      = 18'h1ffff;
  localparam logic [17:0] D_MIN      = 18'h20000;
  localparam logic [15:0] OUT_MAX    = 16'h7fff;
  localparam logic [15:0] OUT_MIN    = 16'h8000;
  localparam logic [15:0] CODE_MID   = 16'h8000;

  // Offset-binary to two's complement: flip the MSB.
  function automatic logic [15:0] offset_to_twos(input logic [15:0] v);
    return {~v[15], v[14:0]};
  endfunction

  // Two's complement to offset-binary: flip the MSB.
  function automatic logic [15:0] twos_to_offset(input logic [15:0] v);
    return {~v[15], v[14:0]};
  endfunction

endpackage

// File: rtl/dac_spi_tx.sv
// AD5662-style serializer: one 24-bit frame (8'h00 + 16-bit code), MSB first.
// SCLK idles low; each bit period starts with a rising edge (din updates)
// and the DAC samples on the following falling edge. sync_n of the target
// channel stays low from the load edge until after the last falling edge.
module dac_spi_tx
  import dac_bank_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int SCLK_DIV = 2
) (
  input  logic            state_clk,
  input  logic            reset,
  input  logic            load,
  input  logic [15:0]     code,
  input  logic [2:0]      ch,
  output logic [N_CH-1:0] sync_n,
  output logic            sclk,
  output logic            din,
  output logic            done
);

  localparam int DW     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int HALVES = 2 * FRAME_BITS;

  logic                  active;
  logic [DW-1:0]         div_cnt;
  logic [5:0]            half_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame;
  logic                  half_end;

  assign frame    = {8'h00, code};
  assign half_end = (div_cnt == DW'(SCLK_DIV - 1));
  // done is high in the final state_clk cycle of the frame.
  assign done     = active && half_end && (half_cnt == 6'(HALVES - 1));

  // Frame sequencer: divide state_clk into SCLK half periods and shift bits.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      sync_n   <= '1;
      sclk     <= 1'b0;
      din      <= 1'b0;
    end else if (load) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= frame << 1;
      sync_n   <= ~(N_CH'(1) << ch);
      sclk     <= 1'b1;
      din      <= frame[FRAME_BITS-1];
    end else if (active && half_end) begin
      div_cnt <= '0;
      if (done) begin
        active <= 1'b0;
        sync_n <= '1;
      end else begin
        half_cnt <= half_cnt + 6'd1;
        sclk     <= ~sclk;
        if (!sclk) begin
          din   <= shreg[FRAME_BITS-1];
          shreg <= shreg << 1;
        end
      end
    end else if (active) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_channel_bank.sv
// Multi-channel DAC front end: per-channel optional high-pass filter,
// noise deadzone, gain with saturation, threshold comparator and an SPI
// serializer with one SYNC_n line per channel.
// Optional feature: define DAC_CHANNEL_BANK_HPF_EN to build the per-channel
// HPF state array and multiplier; otherwise the raw sample is always used.
module dac_channel_bank
  import dac_bank_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int SCLK_DIV = 2,
  parameter int SYNC_GAP = 4
) (
  input  logic            state_clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_ch,
  input  logic [15:0]     in_data,
  input  logic [15:0]     hpf_coeff,
  input  logic            hpf_en,
  input  logic [2:0]      gain,
  input  logic [6:0]      noise_suppress,
  input  logic [N_CH-1:0] ch_en,
  input  logic [15:0]     thrsh,
  input  logic            thrsh_pol,
  output logic [N_CH-1:0] thrsh_out,
  output logic [N_CH-1:0] dac_sync_n,
  output logic            dac_sclk,
  output logic            dac_din,
  output logic [15:0]     dac_register,
  output logic            busy
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int GW = $clog2(SYNC_GAP + 1);

  state_t           fsm_state, fsm_next;
  logic [GW-1:0]    gap_cnt;
  logic             accept, spi_load, spi_done, ch_ok;
  logic [CW-1:0]    ch_idx;

  // Per-sample configuration captured on the accept cycle.
  logic [15:0]      s_data, s_thrsh;
  logic [2:0]       s_ch, s_gain;
  logic [6:0]       s_ns;
  logic             s_pol;
  logic [N_CH-1:0]  s_ch_en;

  logic signed [17:0] x;
  logic [15:0]        f_val, n_val, g_val, code, u_val;
  logic signed [16:0] f_ext, t_ext, n_ext;
  logic signed [22:0] g_wide;
  logic               thr_bit;

  assign accept   = in_valid && in_ready;
  assign ch_ok    = (int'(s_ch) < N_CH);
  assign ch_idx   = s_ch[CW-1:0];
  assign spi_load = (fsm_state == ST_LOAD);
  assign x        = {offset_to_twos(s_data), 2'b00};

`ifdef DAC_CHANNEL_BANK_HPF_EN
  logic [15:0]        s_coeff;
  logic               s_hpf_en;
  logic [31:0]        hpf_state [N_CH];
  logic signed [17:0] state_hi, d, coeff_op;
  logic signed [18:0] diff;
  logic signed [35:0] p;
  logic               unused_p;

  assign state_hi = hpf_state[ch_idx][31:14];
  assign diff     = {x[17], x} - {state_hi[17], state_hi};
  assign d        = (diff[18] != diff[17]) ? (diff[18] ? D_MIN : D_MAX) : diff[17:0];
  assign coeff_op = {1'b0, s_coeff, 1'b0};
  assign unused_p = ^{p[35], p[2:0]};

  // HPF product in FILTER, state accumulation in LOAD.
  // NOTE: the state array is cleared by a loop under reset, so synthesis
  // builds flops rather than RAM; fine for at most eight 32-bit entries.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) hpf_state[i] <= '0;
      p        <= '0;
      s_coeff  <= '0;
      s_hpf_en <= 1'b0;
    end else begin
      if (accept) begin
        s_coeff  <= hpf_coeff;
        s_hpf_en <= hpf_en;
      end
      if (fsm_state == ST_FILTER) p <= d * coeff_op;
      if (fsm_state == ST_LOAD && ch_ok) hpf_state[ch_idx] <= hpf_state[ch_idx] + p[34:3];
    end
  end
`else
  logic unused_hpf;
  assign unused_hpf = ^{hpf_coeff, hpf_en};
`endif

  // Sample path: filter select, deadzone, gain saturation, code and compare.
  // NOTE: every variable gets a value at the top of the block so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    f_val  = x[17:2];
`ifdef DAC_CHANNEL_BANK_HPF_EN
    if (s_hpf_en) f_val = d[17:2];
`endif
    f_ext = {f_val[15], f_val};
    t_ext = {6'b0, s_ns, 4'b0};
    n_ext = '0;
    if (!f_ext[16] && f_ext > t_ext)      n_ext = f_ext - t_ext;
    else if (f_ext[16] && f_ext < -t_ext) n_ext = f_ext + t_ext;
    n_val  = n_ext[15:0];
    g_wide = {{7{n_val[15]}}, n_val} <<< s_gain;
    if (g_wide > 23'sd32767)       g_val = OUT_MAX;
    else if (g_wide < -23'sd32768) g_val = OUT_MIN;
    else                           g_val = g_wide[15:0];
    code    = s_ch_en[ch_idx] ? twos_to_offset(g_val) : CODE_MID;
    u_val   = twos_to_offset(f_val);
    thr_bit = s_ch_en[ch_idx] && (s_pol ? (u_val >= s_thrsh) : (u_val <= s_thrsh));
  end

  // FSM next state and handshake outputs.
  always_comb begin
    fsm_next = fsm_state;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (fsm_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) fsm_next = ST_FILTER;
      end
      ST_FILTER: fsm_next = ch_ok ? ST_LOAD : ST_IDLE;
      ST_LOAD:   fsm_next = ST_SHIFT;
      ST_SHIFT:  if (spi_done) fsm_next = ST_GAP;
      ST_GAP:    if (gap_cnt == GW'(SYNC_GAP - 1)) fsm_next = ST_IDLE;
      default:   fsm_next = ST_IDLE;
    endcase
  end

  // State register, sample capture, gap counter and LOAD-time outputs.
  always_ff @(posedge state_clk) begin
    if (reset) begin
      fsm_state    <= ST_IDLE;
      gap_cnt      <= '0;
      thrsh_out    <= '0;
      dac_register <= CODE_MID;
      s_data       <= '0;
      s_thrsh      <= '0;
      s_ch         <= '0;
      s_gain       <= '0;
      s_ns         <= '0;
      s_pol        <= 1'b0;
      s_ch_en      <= '0;
    end else begin
      fsm_state <= fsm_next;
      gap_cnt   <= (fsm_state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        s_data  <= in_data;
        s_thrsh <= thrsh;
        s_ch    <= in_ch;
        s_gain  <= gain;
        s_ns    <= noise_suppress;
        s_pol   <= thrsh_pol;
        s_ch_en <= ch_en;
      end
      if (fsm_state == ST_LOAD) begin
        dac_register      <= code;
        thrsh_out[ch_idx] <= thr_bit;
      end
    end
  end

  dac_spi_tx #(
    .N_CH     (N_CH),
    .SCLK_DIV (SCLK_DIV)
  ) u_spi_tx (
    .state_clk (state_clk),
    .reset     (reset),
    .load      (spi_load),
    .code      (code),
    .ch        (s_ch),
    .sync_n    (dac_sync_n),
    .sclk      (dac_sclk),
    .din       (dac_din),
    .done      (spi_done)
  );

endmodule

// File: tb/tb_dac_channel_bank.sv
// Self-checking bench for dac_channel_bank: directed cases plus randomized
// samples compared against an arithmetic reference model; SPI frames are
// decoded from the pins on SCLK falling edges.
module tb_dac_channel_bank;

  localparam int N_CH        = 4;
  localparam int SCLK_DIV    = 2;
  localparam int SYNC_GAP    = 3;
  localparam int BUSY_CYCLES = 2 + 48 * SCLK_DIV + SYNC_GAP;
`ifdef DAC_CHANNEL_BANK_HPF_EN
  localparam bit HPF_BUILT = 1'b1;
`else
  localparam bit HPF_BUILT = 1'b0;
`endif

  typedef struct {
    int data, ch, gain, ns, hpf, coeff, thrsh, pol, en;
  } txn_t;

  logic            state_clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_ch = '0;
  logic [15:0]     in_data = '0;
  logic [15:0]     hpf_coeff = '0;
  logic            hpf_en = 1'b0;
  logic [2:0]      gain = '0;
  logic [6:0]      noise_suppress = '0;
  logic [N_CH-1:0] ch_en = '0;
  logic [15:0]     thrsh = '0;
  logic            thrsh_pol = 1'b0;
  logic [N_CH-1:0] thrsh_out, dac_sync_n;
  logic            dac_sclk, dac_din, busy;
  logic [15:0]     dac_register;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state.
  int              m_state [N_CH];
  logic [15:0]     m_reg;
  logic [N_CH-1:0] m_thr;

  dac_channel_bank #(
    .N_CH (N_CH), .SCLK_DIV (SCLK_DIV), .SYNC_GAP (SYNC_GAP)
  ) dut (
    .state_clk (state_clk), .reset (reset), .in_valid (in_valid),
    .in_ready (in_ready), .in_ch (in_ch), .in_data (in_data),
    .hpf_coeff (hpf_coeff), .hpf_en (hpf_en), .gain (gain),
    .noise_suppress (noise_suppress), .ch_en (ch_en), .thrsh (thrsh),
    .thrsh_pol (thrsh_pol), .thrsh_out (thrsh_out), .dac_sync_n (dac_sync_n),
    .dac_sclk (dac_sclk), .dac_din (dac_din), .dac_register (dac_register),
    .busy (busy)
  );

  always #5 state_clk = ~state_clk;
  always @(posedge state_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic txn_t mk(input int data, ch, gain, ns, hpf, coeff, thrsh, pol, en);
    txn_t t;
    t.data = data; t.ch = ch; t.gain = gain; t.ns = ns; t.hpf = hpf;
    t.coeff = coeff; t.thrsh = thrsh; t.pol = pol; t.en = en;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_state[i] = 0;
    m_reg = 16'h8000;
    m_thr = '0;
  endtask

  // Behavioural reference: signed integer arithmetic on the sample value.
  task automatic model_apply(input txn_t t, output int code);
    int x, d, f, thr, n, g, u, en;
    longint p;
    code = int'(m_reg);
    if (t.ch >= N_CH) return;
    x = (t.data - 32768) * 4;
    d = x - (m_state[t.ch] >>> 14);
    if (d > 131071)  d = 131071;
    if (d < -131072) d = -131072;
    f = (HPF_BUILT && t.hpf != 0) ? (d >>> 2) : (x / 4);
    thr = t.ns * 16;
    if (f > thr)       n = f - thr;
    else if (f < -thr) n = f + thr;
    else               n = 0;
    g = n * (1 << t.gain);
    if (g > 32767)  g = 32767;
    if (g < -32768) g = -32768;
    en = (t.en >> t.ch) & 1;
    u = f + 32768;
    code = (en != 0) ? g + 32768 : 32768;
    m_thr[t.ch] = (en != 0) && ((t.pol != 0) ? (u >= t.thrsh) : (u <= t.thrsh));
    m_reg = code[15:0];
    if (HPF_BUILT) begin
      p = longint'(d) * longint'(t.coeff * 2);
      m_state[t.ch] = int'(longint'(m_state[t.ch]) + (p >>> 3));
    end
  endtask

  task automatic drive(input txn_t t);
    in_data = 16'(t.data); in_ch = 3'(t.ch); gain = 3'(t.gain);
    noise_suppress = 7'(t.ns); hpf_en = t.hpf[0]; hpf_coeff = 16'(t.coeff);
    thrsh = 16'(t.thrsh); thrsh_pol = t.pol[0]; ch_en = N_CH'(t.en);
  endtask

  // Offer one sample, decode the resulting frame from the pins and compare.
  // With abort_bits > 0 it returns as soon as that many bits were seen.
  task automatic run_txn(input txn_t t, input int abort_bits, output int got_code);
    int wc, busy_cyc, nbits, proto_err, exp_code;
    logic [23:0] frame;
    logic [N_CH-1:0] own;
    logic prev_sclk, prev_din;
    bit valid;
    valid = (t.ch < N_CH);
    own = valid ? N_CH'(1) << t.ch : '0;
    drive(t);
    in_valid = 1'b1;
    wc = 0;
    while (!in_ready && wc < 1000) begin @(negedge state_clk); wc++; end
    if (!in_ready) begin
      check("accept_timeout", 32'(wc), 32'(0));
      in_valid = 1'b0;
      got_code = 0;
      return;
    end
    prev_sclk = dac_sclk; prev_din = dac_din;
    @(negedge state_clk);
    in_valid = 1'b0;
    // Scramble the inputs: only the accept-cycle values may matter.
    in_data = 16'($urandom); gain = 3'($urandom); noise_suppress = 7'($urandom);
    ch_en = N_CH'($urandom); thrsh = 16'($urandom); thrsh_pol = 1'($urandom);
    hpf_en = 1'($urandom); hpf_coeff = 16'($urandom); in_ch = 3'($urandom);
    model_apply(t, exp_code);
    busy_cyc = 0; nbits = 0; frame = '0; proto_err = 0;
    while (busy && busy_cyc < 1000) begin
      busy_cyc++;
      if (dac_din !== prev_din && !(dac_sclk && !prev_sclk)) proto_err++;
      if (prev_sclk && !dac_sclk && valid && !dac_sync_n[t.ch]) begin
        frame = {frame[22:0], dac_din};
        nbits++;
      end
      if (((~dac_sync_n) & ~own) != '0) proto_err++;
      if (dac_sclk && (&dac_sync_n)) proto_err++;
      prev_sclk = dac_sclk; prev_din = dac_din;
      if (abort_bits > 0 && nbits == abort_bits) begin
        got_code = 0;
        return;
      end
      @(negedge state_clk);
    end
    if (!(&dac_sync_n) || dac_sclk) proto_err++;
    got_code = int'(frame[15:0]);
    check("busy_cycles", 32'(busy_cyc), valid ? 32'(BUSY_CYCLES) : 32'(1));
    check("frame_bits", 32'(nbits), valid ? 32'(24) : 32'(0));
    if (valid) check("frame_data", 32'(frame), 32'(exp_code[15:0]));
    check("dac_register", 32'(dac_register), 32'(m_reg));
    check("thrsh_out", 32'(thrsh_out), 32'(m_thr));
    check("spi_protocol", 32'(proto_err), 32'(0));
  endtask

  initial begin
    int code, prev_code, wc;
    int acc [3];
    txn_t t;
    model_reset();
    repeat (3) @(negedge state_clk);
    reset = 1'b0;
    @(negedge state_clk);
    check("rst_sync_n", 32'(dac_sync_n), 32'({N_CH{1'b1}}));
    check("rst_sclk", 32'(dac_sclk), 32'(0));
    check("rst_din", 32'(dac_din), 32'(0));
    check("rst_thrsh_out", 32'(thrsh_out), 32'(0));
    check("rst_dac_register", 32'(dac_register), 32'(16'h8000));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Plain pass-through, gain saturation both ways, deadzone.
    run_txn(mk(16'hA000, 2, 0, 0, 0, 0, 16'h8000, 1, 4'hF), 0, code);
    check("pass_code", 32'(code), 32'(16'hA000));
    check("pass_sync_only_ch2", 32'(dac_register), 32'(16'hA000));
    run_txn(mk(16'hA000, 2, 3, 0, 0, 0, 16'h8000, 1, 4'hF), 0, code);
    check("gain_sat_pos", 32'(code), 32'(16'hFFFF));
    run_txn(mk(16'h6000, 2, 3, 0, 0, 0, 16'h8000, 0, 4'hF), 0, code);
    check("gain_sat_neg", 32'(code), 32'(16'h0000));
    run_txn(mk(16'h8010, 2, 0, 2, 0, 0, 16'h8000, 1, 4'hF), 0, code);
    check("ns_inside", 32'(code), 32'(16'h8000));
    run_txn(mk(16'h8030, 2, 0, 2, 0, 0, 16'h8000, 1, 4'hF), 0, code);
    check("ns_outside", 32'(code), 32'(16'h8010));
    run_txn(mk(16'hC000, 1, 0, 0, 0, 0, 16'h8000, 1, 4'hD), 0, code);
    check("ch_disabled", 32'(code), 32'(16'h8000));

    // DC into the HPF on ch0: output must not rise and stays at/above mid.
    prev_code = 32'hFFFF;
    for (int i = 0; i < 250; i++) begin
      run_txn(mk(16'hC000, 0, 0, 0, 1, 16'h0100, 16'h8000, 1, 4'hF), 0, code);
      check("dc_monotonic", 32'(code <= prev_code && code >= 16'h8000), 32'(1));
      prev_code = code;
    end
    run_txn(mk(16'hC000, 1, 0, 0, 1, 16'h0100, 16'h8000, 1, 4'hF), 0, code);
    check("ch1_state_zero", 32'(code), 32'(16'hC000));

    // Out-of-range channel: no frame, no output change.
    run_txn(mk(16'h1234, 7, 0, 0, 0, 0, 16'h0000, 1, 4'hF), 0, code);

    // Back-to-back: in_valid held high; accepts are one busy run plus the
    // accepting IDLE cycle apart.
    t = mk(16'h9000, 3, 1, 0, 0, 0, 16'h9000, 1, 4'hF);
    drive(t);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wc = 0;
      while (!in_ready && wc < 1000) begin @(negedge state_clk); wc++; end
      check("b2b_ready", 32'(in_ready), 32'(1));
      acc[k] = cyc;
      model_apply(t, code);
      @(negedge state_clk);
    end
    in_valid = 1'b0;
    wc = 0;
    while (busy && wc < 1000) begin @(negedge state_clk); wc++; end
    check("b2b_spacing_0", 32'(acc[1] - acc[0]), 32'(BUSY_CYCLES + 1));
    check("b2b_spacing_1", 32'(acc[2] - acc[1]), 32'(BUSY_CYCLES + 1));
    check("b2b_register", 32'(dac_register), 32'(m_reg));
    check("b2b_thrsh_out", 32'(thrsh_out), 32'(m_thr));

    // Reset in the middle of a frame.
    run_txn(mk(16'h5555, 1, 0, 0, 0, 0, 16'h0000, 1, 4'hF), 10, code);
    reset = 1'b1;
    @(negedge state_clk);
    check("midrst_sync_n", 32'(dac_sync_n), 32'({N_CH{1'b1}}));
    check("midrst_sclk", 32'(dac_sclk), 32'(0));
    check("midrst_din", 32'(dac_din), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_register", 32'(dac_register), 32'(16'h8000));
    check("midrst_thrsh_out", 32'(thrsh_out), 32'(0));
    reset = 1'b0;
    model_reset();
    @(negedge state_clk);
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    run_txn(mk(16'h7777, 0, 0, 0, 1, 16'h8000, 16'h7000, 0, 4'hF), 0, code);

    // Randomized samples, including invalid channels and disabled outputs.
    for (int i = 0; i < 150; i++) begin
      t = mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 7)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 127)) : 0,
             int'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 15)));
      run_txn(t, 0, code);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
